wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_if.sv | 42 ++++
 rtl/wb_stage.sv | 127 ++++++++++++
 tb/tb_wb_stage.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// Bundle between the MEM stage and the write-back stage.
// The master drives the MEM/WB pipeline inputs plus stall/flush, and the slave
// (wb_stage) returns the register-file write port, the forwarding copy,
// the sticky misalign flag and the retire counter.
interface wb_stage_if #(
  parameter int WIDTH = 32
);
  // MEM-stage inputs to the pipeline register
  logic             mem_valid;
  logic             mem_regwrite;
  logic             mem_memtoreg;
  logic [4:0]       mem_rd;
  logic [WIDTH-1:0] mem_alu_result;
  logic [WIDTH-1:0] mem_load_data;
  logic [2:0]       mem_load_type;
  logic             stall;
  logic             flush;

  // Write-back results
  logic             regwrite;
  logic [4:0]       address_wb;
  logic [WIDTH-1:0] data_wb;
  logic             fwd_valid;
  logic [4:0]       fwd_rd;
  logic [WIDTH-1:0] fwd_data;
  logic             misalign_err;
  logic [31:0]      retire_count;

  modport master (
    output mem_valid, mem_regwrite, mem_memtoreg, mem_rd,
           mem_alu_result, mem_load_data, mem_load_type, stall, flush,
    input  regwrite, address_wb, data_wb, fwd_valid, fwd_rd, fwd_data,
           misalign_err, retire_count
  );

  modport slave (
    input  mem_valid, mem_regwrite, mem_memtoreg, mem_rd,
           mem_alu_result, mem_load_data, mem_load_type, stall, flush,
    output regwrite, address_wb, data_wb, fwd_valid, fwd_rd, fwd_data,
           misalign_err, retire_count
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back pipeline stage: MEM/WB register, load byte/halfword extraction,
// register-file write enable, forwarding copy, misaligned-load detection and
// a count of instructions captured into WB.
// Every output is derived from the latched MEM/WB state only, so data_wb is
// stable for the whole cycle (register file may write on posedge and read on
// negedge).
module wb_stage #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,   // synchronous, active-low
  wb_stage_if.slave  bus
);

  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LHU = 3'b010;
  localparam logic [2:0] LT_LB  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;

  // MEM/WB pipeline register
  logic             valid_reg;
  logic             regwrite_reg;
  logic             memtoreg_reg;
  logic [4:0]       rd_reg;
  logic [WIDTH-1:0] alu_reg;
  logic [WIDTH-1:0] load_data_reg;
  logic [2:0]       load_type_reg;

  logic             misalign_err_reg;
  logic [31:0]      retire_count_reg;

  // Derived write-back signals
  logic [1:0]       byte_off;
  logic [7:0]       byte_lane [4];
  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;
  logic [WIDTH-1:0] load_ext;
  logic [WIDTH-1:0] wb_data;
  logic             is_half;
  logic             is_byte;
  logic             misaligned;
  logic             wr_en;

  assign byte_off = alu_reg[1:0];

  // Split the latched load word into its four little-endian byte lanes
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lane[gi] = load_data_reg[8*gi+7 -: 8];
    end
  endgenerate

  // Pipeline register: reset > flush > stall > capture. Reset zeroes every
  // field so the write-back outputs read as zero right after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_reg     <= 1'b0;
      regwrite_reg  <= 1'b0;
      memtoreg_reg  <= 1'b0;
      rd_reg        <= 5'd0;
      alu_reg       <= '0;
      load_data_reg <= '0;
      load_type_reg <= LT_LW;
    end else if (bus.flush) begin
      valid_reg     <= 1'b0;
    end else if (!bus.stall) begin
      valid_reg     <= bus.mem_valid;
      regwrite_reg  <= bus.mem_regwrite;
      memtoreg_reg  <= bus.mem_memtoreg;
      rd_reg        <= bus.mem_rd;
      alu_reg       <= bus.mem_alu_result;
      load_data_reg <= bus.mem_load_data;
      load_type_reg <= bus.mem_load_type;
    end
  end

  // Sticky misaligned-load flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      misalign_err_reg <= 1'b0;
    end else if (misaligned) begin
      misalign_err_reg <= 1'b1;
    end
  end

  // Count real instructions captured into WB; wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (!rst) begin
      retire_count_reg <= 32'd0;
    end else if (!bus.flush && !bus.stall && bus.mem_valid) begin
      retire_count_reg <= retire_count_reg + 32'd1;
    end
  end

  // Load extraction, misalign detection and final write-back selection.
  // Unknown load types fall back to word behaviour.
  always_comb begin
    sel_byte = byte_lane[byte_off];
    sel_half = byte_off[1] ? load_data_reg[31:16] : load_data_reg[15:0];
    is_half  = (load_type_reg == LT_LH) || (load_type_reg == LT_LHU);
    is_byte  = (load_type_reg == LT_LB) || (load_type_reg == LT_LBU);
    load_ext = load_data_reg;
    case (load_type_reg)
      LT_LH:   load_ext = {{(WIDTH-16){sel_half[15]}}, sel_half};
      LT_LHU:  load_ext = {{(WIDTH-16){1'b0}}, sel_half};
      LT_LB:   load_ext = {{(WIDTH-8){sel_byte[7]}}, sel_byte};
      LT_LBU:  load_ext = {{(WIDTH-8){1'b0}}, sel_byte};
      default: load_ext = load_data_reg;
    endcase
    wb_data    = memtoreg_reg ? load_ext : alu_reg;
    misaligned = valid_reg && memtoreg_reg &&
                 ((!is_half && !is_byte && (byte_off != 2'b00)) ||
                  (is_half && byte_off[0]));
    wr_en      = valid_reg && regwrite_reg && (rd_reg != 5'd0) && !misaligned;
  end

  assign bus.regwrite     = wr_en;
  assign bus.address_wb   = rd_reg;
  assign bus.data_wb      = wb_data;
  assign bus.fwd_valid    = wr_en;
  assign bus.fwd_rd       = rd_reg;
  assign bus.fwd_data     = wb_data;
  assign bus.misalign_err = misalign_err_reg;
  assign bus.retire_count = retire_count_reg;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases for the documented
// examples followed by randomized traffic, all checked against a
// behavioural model of the stage's rules.
module tb_wb_stage;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  wb_stage_if #(.WIDTH(32)) bus ();

  wb_stage #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state: what the stage currently holds
  logic        m_valid, m_rw, m_m2r;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_ld;
  logic [2:0]  m_lt;
  logic        m_known;   // held fields are defined (not after a flush)
  logic        m_err;
  logic [31:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_word_type(input logic [2:0] lt);
    return (lt == 3'd0) || (lt > 3'd4);
  endfunction

  function automatic logic model_mis();
    int off;
    off = int'(m_alu % 4);
    if (!m_valid || !m_m2r) return 1'b0;
    if (is_word_type(m_lt)) return off != 0;
    if (m_lt == 3'd1 || m_lt == 3'd2) return (off % 2) == 1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_data();
    int unsigned off, b, h;
    off = m_alu % 4;
    b = (m_ld >> (8 * off)) % 256;
    h = (m_ld >> (16 * (off / 2))) % 65536;
    if (!m_m2r) return m_alu;
    case (m_lt)
      3'd1:    return (h >= 32768) ? h - 32'h10000 : h;
      3'd2:    return h;
      3'd3:    return (b >= 128) ? b - 32'h100 : b;
      3'd4:    return b;
      default: return m_ld;
    endcase
  endfunction

  function automatic logic model_we();
    return m_valid && m_rw && (m_rd != 5'd0) && !model_mis();
  endfunction

  task automatic set_in(input logic v, input logic rw, input logic m2r,
                        input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] ld, input logic [2:0] lt);
    bus.mem_valid      = v;
    bus.mem_regwrite   = rw;
    bus.mem_memtoreg   = m2r;
    bus.mem_rd         = rd;
    bus.mem_alu_result = alu;
    bus.mem_load_data  = ld;
    bus.mem_load_type  = lt;
  endtask

  // Advance one rising edge, update the model with the sampled inputs,
  // then compare every output shortly after the edge.
  task automatic step();
    logic old_mis;
    @(posedge clk);
    old_mis = model_mis();
    if (!rst) begin
      m_valid = 0; m_rw = 0; m_m2r = 0; m_rd = 0; m_alu = 0; m_ld = 0; m_lt = 0;
      m_known = 1; m_err = 0; m_cnt = 0;
    end else begin
      if (old_mis) m_err = 1;
      if (bus.flush) begin
        m_valid = 0;
        m_known = 0;
      end else if (!bus.stall) begin
        m_valid = bus.mem_valid;   m_rw = bus.mem_regwrite; m_m2r = bus.mem_memtoreg;
        m_rd    = bus.mem_rd;      m_alu = bus.mem_alu_result;
        m_ld    = bus.mem_load_data; m_lt = bus.mem_load_type;
        m_known = 1;
        if (bus.mem_valid) m_cnt = m_cnt + 32'd1;
      end
    end
    #1;
    chk("regwrite", 32'(bus.regwrite), 32'(model_we()));
    chk("fwd_valid", 32'(bus.fwd_valid), 32'(model_we()));
    chk("misalign_err", 32'(bus.misalign_err), 32'(m_err));
    chk("retire_count", bus.retire_count, m_cnt);
    if (m_known) begin
      chk("address_wb", 32'(bus.address_wb), 32'(m_rd));
      chk("data_wb", bus.data_wb, model_data());
      chk("fwd_rd", 32'(bus.fwd_rd), 32'(m_rd));
      chk("fwd_data", bus.fwd_data, model_data());
    end
  endtask

  initial begin
    logic [31:0] ldw;
    ldw = 32'h80FF7F01;
    m_valid = 0; m_rw = 0; m_m2r = 0; m_rd = 0; m_alu = 0; m_ld = 0; m_lt = 0;
    m_known = 0; m_err = 0; m_cnt = 0;
    rst = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    set_in(1, 1, 0, 5'd9, 32'hDEADBEEF, 32'h0, 3'd0);

    // Reset with a pending capture: everything reads zero
    step();
    step();
    chk("rst_data_wb", bus.data_wb, 32'h0);
    chk("rst_address_wb", 32'(bus.address_wb), 32'h0);
    rst = 1'b1;

    // ALU write-back example
    set_in(1, 1, 0, 5'd5, 32'h12345678, 32'h0, 3'd0);
    step();
    chk("alu_data", bus.data_wb, 32'h12345678);
    chk("alu_count", bus.retire_count, 32'd1);

    // Load extraction examples
    set_in(1, 1, 1, 5'd3, 32'h00000003, ldw, 3'd3); step();
    chk("lb_off3", bus.data_wb, 32'hFFFFFF80);
    set_in(1, 1, 1, 5'd3, 32'h00000003, ldw, 3'd4); step();
    chk("lbu_off3", bus.data_wb, 32'h00000080);
    set_in(1, 1, 1, 5'd3, 32'h00000002, ldw, 3'd1); step();
    chk("lh_off2", bus.data_wb, 32'hFFFF80FF);
    set_in(1, 1, 1, 5'd3, 32'h00000000, ldw, 3'd2); step();
    chk("lhu_off0", bus.data_wb, 32'h00007F01);

    // Write to r0 suppressed; misaligned LW suppressed and flagged
    set_in(1, 1, 0, 5'd0, 32'h11111111, 32'h0, 3'd0); step();
    chk("r0_regwrite", 32'(bus.regwrite), 32'd0);
    set_in(1, 1, 1, 5'd4, 32'h00000102, ldw, 3'd0); step();
    chk("mis_regwrite", 32'(bus.regwrite), 32'd0);
    set_in(0, 0, 0, 5'd0, 32'h0, 32'h0, 3'd0);
    step();
    chk("mis_err_set", 32'(bus.misalign_err), 32'd1);
    step(); step();

    // Stall holds a write; flush with stall kills it
    set_in(1, 1, 0, 5'd7, 32'hCAFEF00D, 32'h0, 3'd0); step();
    bus.stall = 1'b1;
    set_in(1, 1, 0, 5'd12, 32'h0BADF00D, 32'h0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_rd", 32'(bus.address_wb), 32'd7);
    end
    bus.flush = 1'b1; step();
    chk("flush_regwrite", 32'(bus.regwrite), 32'd0);
    bus.flush = 1'b0;

    // Reset for one edge in the middle of a stall
    bus.stall = 1'b0;
    set_in(1, 1, 0, 5'd8, 32'h55AA55AA, 32'h0, 3'd0); step();
    bus.stall = 1'b1; step();
    rst = 1'b0; step();
    rst = 1'b1;
    chk("rst_stall_count", bus.retire_count, 32'd0);
    chk("rst_stall_err", 32'(bus.misalign_err), 32'd0);
    step(); step();
    bus.stall = 1'b0; step();

    // Counter wrap: preload near the top while stalled, then capture
    bus.stall = 1'b1;
    force dut.retire_count_reg = 32'hFFFFFFFE;
    #1;
    release dut.retire_count_reg;
    m_cnt = 32'hFFFFFFFE;
    step();
    bus.stall = 1'b0;
    set_in(1, 0, 0, 5'd1, 32'h1, 32'h0, 3'd0);
    step();
    chk("cnt_max", bus.retire_count, 32'hFFFFFFFF);
    step();
    chk("cnt_wrap", bus.retire_count, 32'h00000000);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 49) != 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      bus.stall = ($urandom_range(0, 4) == 0);
      set_in(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
             $urandom, $urandom, 3'($urandom));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
